// File: rtl/pipe_stall_responder_pkg.sv
// Shared constants, per-stage field layouts and T_new arithmetic for the
// pipeline stall responder.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0;
    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam int          TNEW_W       = 2;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    typedef logic [TNEW_W-1:0] tnew_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } fd_t;

    // E_pc is kept out of this group: it survives a bubble while the rest clears.
    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [4:0]  rs_base;
        logic [4:0]  rt;
        logic [4:0]  wn;
        tnew_t       tnew;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] ext_imm;
    } de_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [4:0]  rs_base;
        logic [4:0]  rt;
        logic [4:0]  wn;
        tnew_t       tnew;
        logic [31:0] rt_val;
        logic [31:0] result;
    } em_t;

    function automatic tnew_t sat_dec(input tnew_t x);
        return (x == '0) ? '0 : tnew_t'(x - tnew_t'(1));
    endfunction

endpackage

// File: rtl/pipe_stall_responder_if.sv
// Pipeline-side bundle of the stall responder: D-stage inputs in, per-stage
// register contents out.
interface pipe_stall_responder_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             stall;
    logic [31:0]      npc;
    logic [31:0]      F_instr;
    logic [4:0]       D_rs_base;
    logic [4:0]       D_rt;
    logic [4:0]       D_REG_write_number;
    tnew_t            D_T_new;
    logic [31:0]      D_rs_val;
    logic [31:0]      D_rt_val;
    logic [31:0]      D_ext_imm;
    logic [31:0]      E_result;

    logic [31:0]      F_pc;
    logic [31:0]      D_pc;
    logic [31:0]      D_instr;
    logic             D_valid;
    logic [31:0]      E_pc;
    logic [31:0]      E_instr;
    logic             E_valid;
    logic [4:0]       E_rs_base;
    logic [4:0]       E_rt;
    logic [4:0]       E_REG_write_number;
    tnew_t            E_T_new;
    logic [31:0]      E_rs_val;
    logic [31:0]      E_rt_val;
    logic [31:0]      E_ext_imm;
    logic [31:0]      M_pc;
    logic [31:0]      M_instr;
    logic             M_valid;
    logic [4:0]       M_rs_base;
    logic [4:0]       M_rt;
    logic [4:0]       M_REG_write_number;
    tnew_t            M_T_new;
    logic [31:0]      M_rt_val;
    logic [31:0]      M_result;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stall, npc, F_instr, D_rs_base, D_rt, D_REG_write_number, D_T_new,
               D_rs_val, D_rt_val, D_ext_imm, E_result,
        input  F_pc, D_pc, D_instr, D_valid,
               E_pc, E_instr, E_valid, E_rs_base, E_rt, E_REG_write_number, E_T_new,
               E_rs_val, E_rt_val, E_ext_imm,
               M_pc, M_instr, M_valid, M_rs_base, M_rt, M_REG_write_number, M_T_new,
               M_rt_val, M_result, stall_cnt
    );

    modport slave (
        input  stall, npc, F_instr, D_rs_base, D_rt, D_REG_write_number, D_T_new,
               D_rs_val, D_rt_val, D_ext_imm, E_result,
        output F_pc, D_pc, D_instr, D_valid,
               E_pc, E_instr, E_valid, E_rs_base, E_rt, E_REG_write_number, E_T_new,
               E_rs_val, E_rt_val, E_ext_imm,
               M_pc, M_instr, M_valid, M_rs_base, M_rt, M_REG_write_number, M_T_new,
               M_rt_val, M_result, stall_cnt
    );

endinterface

// File: rtl/pipe_stall_responder_reg_field.sv
// Generic pipeline register: async active-low reset to RST_VAL, synchronous
// clear (bubble) taking priority over the load enable.
module pipe_reg_field #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= RST_VAL;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_stall_responder.sv
// Responder side of the hazard stall interface: PC, F/D, D/E and E/M registers
// with freeze/bubble handling and a saturating stall-cycle counter.
module pipe_stall_responder
    import pipe_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipe_stall_responder_if.slave  bus
);

    logic             run;
    logic [31:0]      pc_q;
    fd_t              fd_d, fd_q;
    logic [31:0]      epc_q;
    de_t              de_d, de_q;
    em_t              em_d, em_q;
    logic [CNT_W-1:0] cnt_q;

    assign run = ~bus.stall;

    pipe_reg_field #(.W(32), .RST_VAL(PC_RESET)) u_pc (
        .clk(clk), .reset_n(reset_n), .en(run), .clr(1'b0), .d(bus.npc), .q(pc_q)
    );

    assign fd_d = '{pc: pc_q, instr: bus.F_instr, valid: 1'b1};

    pipe_reg_field #(.W($bits(fd_t))) u_fd (
        .clk(clk), .reset_n(reset_n), .en(run), .clr(1'b0), .d(fd_d), .q(fd_q)
    );

    // A bubble zeroes write number and T_new, so it can never trip the detector.
    assign de_d = '{
        instr:   fd_q.instr,
        valid:   fd_q.valid,
        rs_base: bus.D_rs_base,
        rt:      bus.D_rt,
        wn:      bus.D_REG_write_number,
        tnew:    sat_dec(bus.D_T_new),
        rs_val:  bus.D_rs_val,
        rt_val:  bus.D_rt_val,
        ext_imm: bus.D_ext_imm
    };

    pipe_reg_field #(.W($bits(de_t))) u_de (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(bus.stall), .d(de_d), .q(de_q)
    );

    pipe_reg_field #(.W(32)) u_de_pc (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0), .d(fd_q.pc), .q(epc_q)
    );

    assign em_d = '{
        pc:      epc_q,
        instr:   de_q.instr,
        valid:   de_q.valid,
        rs_base: de_q.rs_base,
        rt:      de_q.rt,
        wn:      de_q.wn,
        tnew:    sat_dec(de_q.tnew),
        rt_val:  de_q.rt_val,
        result:  bus.E_result
    };

    pipe_reg_field #(.W($bits(em_t))) u_em (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0), .d(em_d), .q(em_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (bus.stall && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.F_pc               = pc_q;
    assign bus.D_pc               = fd_q.pc;
    assign bus.D_instr            = fd_q.instr;
    assign bus.D_valid            = fd_q.valid;
    assign bus.E_pc               = epc_q;
    assign bus.E_instr            = de_q.instr;
    assign bus.E_valid            = de_q.valid;
    assign bus.E_rs_base          = de_q.rs_base;
    assign bus.E_rt               = de_q.rt;
    assign bus.E_REG_write_number = de_q.wn;
    assign bus.E_T_new            = de_q.tnew;
    assign bus.E_rs_val           = de_q.rs_val;
    assign bus.E_rt_val           = de_q.rt_val;
    assign bus.E_ext_imm          = de_q.ext_imm;
    assign bus.M_pc               = em_q.pc;
    assign bus.M_instr            = em_q.instr;
    assign bus.M_valid            = em_q.valid;
    assign bus.M_rs_base          = em_q.rs_base;
    assign bus.M_rt               = em_q.rt;
    assign bus.M_REG_write_number = em_q.wn;
    assign bus.M_T_new            = em_q.tnew;
    assign bus.M_rt_val           = em_q.rt_val;
    assign bus.M_result           = em_q.result;
    assign bus.stall_cnt          = cnt_q;

endmodule

// File: tb/tb_pipe_stall_responder.sv
// Scoreboard bench: stimulus pushes the model's expected post-edge snapshot,
// a monitor pops and compares after every rising edge.
module tb_pipe_stall_responder;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_responder_if #(.CNT_W(32)) ifc ();
    pipe_stall_responder_if #(.CNT_W(2))  ifc2 ();

    pipe_stall_responder #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .bus(ifc.slave)
    );
    pipe_stall_responder #(.PC_RESET(32'h0000_3000), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(ifc2.slave)
    );

    assign ifc2.stall              = ifc.stall;
    assign ifc2.npc                = ifc.npc;
    assign ifc2.F_instr            = ifc.F_instr;
    assign ifc2.D_rs_base          = ifc.D_rs_base;
    assign ifc2.D_rt               = ifc.D_rt;
    assign ifc2.D_REG_write_number = ifc.D_REG_write_number;
    assign ifc2.D_T_new            = ifc.D_T_new;
    assign ifc2.D_rs_val           = ifc.D_rs_val;
    assign ifc2.D_rt_val           = ifc.D_rt_val;
    assign ifc2.D_ext_imm          = ifc.D_ext_imm;
    assign ifc2.E_result           = ifc.E_result;

    // One instruction slot as it sits in a stage.
    typedef struct {
        logic [31:0] pc, instr;
        logic        valid;
        logic [4:0]  rs, rt, wn;
        logic [1:0]  tn;
        logic [31:0] rsv, rtv, imm, res;
    } slot_t;

    typedef struct {
        logic [31:0] fpc;
        slot_t       d, e, m;
        longint      cnt, cnt2;
    } snap_t;

    snap_t expq[$];
    snap_t cur;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [1:0] dec(input logic [1:0] x);
        int v;
        v = int'(x) - 1;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    function automatic snap_t rst_snap();
        snap_t s;
        s.fpc = 32'h0000_3000;
        s.d = '{default: '0};
        s.e = '{default: '0};
        s.m = '{default: '0};
        s.cnt = 0;
        s.cnt2 = 0;
        return s;
    endfunction

    // Instruction-level view: what sits in each stage after the coming edge.
    function automatic snap_t step(input snap_t s);
        snap_t n;
        n = s;
        n.m = s.e;
        n.m.tn = dec(s.e.tn);
        n.m.res = ifc.E_result;
        if (ifc.stall) begin
            n.e = '{default: '0};
            n.e.pc = s.d.pc;
            n.e.instr = NOP_INSTR;
            n.e.wn = REG_ZERO;
            n.cnt = (s.cnt >= 64'hFFFF_FFFF) ? s.cnt : s.cnt + 1;
            n.cnt2 = (s.cnt2 >= 3) ? 3 : s.cnt2 + 1;
        end else begin
            n.e = '{pc: s.d.pc, instr: s.d.instr, valid: s.d.valid,
                    rs: ifc.D_rs_base, rt: ifc.D_rt, wn: ifc.D_REG_write_number,
                    tn: dec(ifc.D_T_new), rsv: ifc.D_rs_val, rtv: ifc.D_rt_val,
                    imm: ifc.D_ext_imm, res: 32'h0};
            n.d = '{default: '0};
            n.d.pc = s.fpc;
            n.d.instr = ifc.F_instr;
            n.d.valid = 1'b1;
            n.fpc = ifc.npc;
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all(input snap_t x);
        check("F_pc", 128'(ifc.F_pc), 128'(x.fpc));
        check("FD", 128'({ifc.D_pc, ifc.D_instr, ifc.D_valid}),
              128'({x.d.pc, x.d.instr, x.d.valid}));
        check("DE_ctl", 128'({ifc.E_pc, ifc.E_instr, ifc.E_valid, ifc.E_rs_base, ifc.E_rt,
                              ifc.E_REG_write_number, ifc.E_T_new}),
              128'({x.e.pc, x.e.instr, x.e.valid, x.e.rs, x.e.rt, x.e.wn, x.e.tn}));
        check("DE_data", 128'({ifc.E_rs_val, ifc.E_rt_val, ifc.E_ext_imm}),
              128'({x.e.rsv, x.e.rtv, x.e.imm}));
        check("EM_ctl", 128'({ifc.M_pc, ifc.M_instr, ifc.M_valid, ifc.M_rs_base, ifc.M_rt,
                              ifc.M_REG_write_number, ifc.M_T_new}),
              128'({x.m.pc, x.m.instr, x.m.valid, x.m.rs, x.m.rt, x.m.wn, x.m.tn}));
        check("EM_data", 128'({ifc.M_rt_val, ifc.M_result}), 128'({x.m.rtv, x.m.res}));
        check("stall_cnt", 128'(ifc.stall_cnt), 128'(x.cnt));
        check("stall_cnt_w2", 128'(ifc2.stall_cnt), 128'(x.cnt2));
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected result.
    task automatic cyc(input logic rn, input logic st, input logic [31:0] pc_n,
                       input logic [31:0] fi, input logic [4:0] wn, input logic [1:0] tn);
        @(negedge clk);
        reset_n = rn;
        ifc.stall = st;
        ifc.npc = pc_n;
        ifc.F_instr = fi;
        ifc.D_rs_base = 5'($urandom);
        ifc.D_rt = 5'($urandom);
        ifc.D_REG_write_number = wn;
        ifc.D_T_new = tn;
        ifc.D_rs_val = $urandom;
        ifc.D_rt_val = $urandom;
        ifc.D_ext_imm = $urandom;
        ifc.E_result = $urandom;
        cur = rn ? step(cur) : rst_snap();
        expq.push_back(cur);
    endtask

    task automatic rcyc(input logic st);
        cyc(1'b1, st, cur.fpc + 32'd4, $urandom, 5'($urandom), 2'($urandom));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) check_all(expq.pop_front());
        end
    end

    initial begin
        ifc.stall = 1'b0;
        ifc.npc = '0;
        ifc.F_instr = '0;
        ifc.D_rs_base = '0;
        ifc.D_rt = '0;
        ifc.D_REG_write_number = '0;
        ifc.D_T_new = '0;
        ifc.D_rs_val = '0;
        ifc.D_rt_val = '0;
        ifc.D_ext_imm = '0;
        ifc.E_result = '0;
        cur = rst_snap();

        repeat (3) cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);
        // Fetch the load, then stall once with it in D.
        cyc(1'b1, 1'b0, 32'h0000_3004, 32'h8C01_0000, 5'd0, 2'd0);
        cyc(1'b1, 1'b1, 32'h0000_3008, 32'h1111_1111, 5'd5, 2'd3);
        cyc(1'b1, 1'b0, 32'h0000_3008, 32'h2222_2222, 5'd5, 2'd3);
        cyc(1'b1, 1'b0, 32'h0000_300C, 32'h3333_3333, 5'd7, 2'd2);
        cyc(1'b1, 1'b0, 32'h0000_3010, 32'h4444_4444, 5'd9, 2'd0);
        cyc(1'b1, 1'b0, 32'h0000_3014, 32'h5555_5555, 5'd1, 2'd1);
        repeat (3) rcyc(1'b1);
        repeat (3) rcyc(1'b0);

        for (int i = 0; i < 300; i++) rcyc($urandom_range(0, 2) == 0);

        // Asynchronous reset in the middle of a stall, between edges.
        rcyc(1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        cur = rst_snap();
        #1;
        check_all(cur);
        repeat (2) cyc(1'b0, 1'b1, $urandom, $urandom, 5'($urandom), 2'($urandom));
        repeat (5) rcyc(1'b1);
        repeat (3) rcyc(1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
